// File: rtl/timestamp_serializer.sv
// Snapshots a BCD date/time on request and streams it as an ASCII frame
// "YY-MM-DD HH:MM:SS.dc" (optionally LF-terminated) over a valid/ready byte port.
module timestamp_serializer #(
  parameter int          SEND_EOL = 1,
  parameter logic [7:0]  DATE_SEP = 8'h2D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [3:0] centesimas,
  input  logic [3:0] decimas,
  input  logic [3:0] unidadesSegundo,
  input  logic [2:0] decenasSegundo,
  input  logic [3:0] unidadesMinuto,
  input  logic [3:0] decenasMinuto,
  input  logic [3:0] unidadesHora,
  input  logic [1:0] decenasHora,
  input  logic [3:0] unidadesDia,
  input  logic [1:0] decenasDia,
  input  logic [3:0] unidadesMes,
  input  logic [0:0] decenasMes,
  input  logic [3:0] unidadesYear,
  input  logic [3:0] decenasYear,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0] LAST_IDX = (SEND_EOL != 0) ? 5'd20 : 5'd19;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state_q;
  logic [4:0]        idx_q;
  logic [13:0][3:0]  snap_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;

  logic [13:0][3:0]  digits_d;
  logic [4:0]        idx_d;
  logic [7:0]        first_byte_d;
  logic [7:0]        next_byte_d;

  function automatic logic [7:0] enc_digit(input logic [3:0] d);
    if (d > 4'd9) return 8'h3F;
    return 8'h30 + {4'h0, d};
  endfunction

  // Snapshot slot k holds the k-th digit of the frame, most significant first.
  function automatic logic [7:0] frame_byte(input logic [4:0] idx, input logic [13:0][3:0] s);
    logic [7:0] b;
    case (idx)
      5'd0:    b = enc_digit(s[0]);
      5'd1:    b = enc_digit(s[1]);
      5'd2:    b = DATE_SEP;
      5'd3:    b = enc_digit(s[2]);
      5'd4:    b = enc_digit(s[3]);
      5'd5:    b = DATE_SEP;
      5'd6:    b = enc_digit(s[4]);
      5'd7:    b = enc_digit(s[5]);
      5'd8:    b = 8'h20;
      5'd9:    b = enc_digit(s[6]);
      5'd10:   b = enc_digit(s[7]);
      5'd11:   b = 8'h3A;
      5'd12:   b = enc_digit(s[8]);
      5'd13:   b = enc_digit(s[9]);
      5'd14:   b = 8'h3A;
      5'd15:   b = enc_digit(s[10]);
      5'd16:   b = enc_digit(s[11]);
      5'd17:   b = 8'h2E;
      5'd18:   b = enc_digit(s[12]);
      5'd19:   b = enc_digit(s[13]);
      5'd20:   b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    digits_d = {centesimas, decimas, unidadesSegundo, {1'b0, decenasSegundo},
                unidadesMinuto, decenasMinuto, unidadesHora, {2'b00, decenasHora},
                unidadesDia, {2'b00, decenasDia}, unidadesMes, {3'b000, decenasMes},
                unidadesYear, decenasYear};
    idx_d        = idx_q + 5'd1;
    first_byte_d = frame_byte(5'd0, digits_d);
    next_byte_d  = frame_byte(idx_d, snap_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 5'd0;
      snap_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            snap_q     <= digits_d;
            idx_q      <= 5'd0;
            tx_data_q  <= first_byte_d;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          // tx_valid is always high here, so tx_ready alone means acceptance
          if (tx_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q    <= IDLE;
              idx_q      <= 5'd0;
              tx_data_q  <= 8'h00;
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              idx_q     <= idx_d;
              tx_data_q <= next_byte_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_timestamp_serializer.sv
// Directed bench for timestamp_serializer: table-driven frames plus
// hand-written sequences for stall, busy-req, back-to-back, abort and no-EOL cases.
module tb_timestamp_serializer;

  logic       clk = 1'b0;
  logic       rst, req, req0, tx_ready;
  logic [3:0] centesimas, decimas, unidadesSegundo, unidadesMinuto, decenasMinuto;
  logic [3:0] unidadesHora, unidadesDia, unidadesMes, unidadesYear, decenasYear;
  logic [2:0] decenasSegundo;
  logic [1:0] decenasHora, decenasDia;
  logic [0:0] decenasMes;
  logic [7:0] tx_data, tx_data0;
  logic       tx_valid, tx_valid0, busy, busy0, done, done0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  timestamp_serializer dut (
    .clk(clk), .rst(rst), .req(req),
    .centesimas(centesimas), .decimas(decimas), .unidadesSegundo(unidadesSegundo),
    .decenasSegundo(decenasSegundo), .unidadesMinuto(unidadesMinuto),
    .decenasMinuto(decenasMinuto), .unidadesHora(unidadesHora), .decenasHora(decenasHora),
    .unidadesDia(unidadesDia), .decenasDia(decenasDia), .unidadesMes(unidadesMes),
    .decenasMes(decenasMes), .unidadesYear(unidadesYear), .decenasYear(decenasYear),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  timestamp_serializer #(.SEND_EOL(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0),
    .centesimas(centesimas), .decimas(decimas), .unidadesSegundo(unidadesSegundo),
    .decenasSegundo(decenasSegundo), .unidadesMinuto(unidadesMinuto),
    .decenasMinuto(decenasMinuto), .unidadesHora(unidadesHora), .decenasHora(decenasHora),
    .unidadesDia(unidadesDia), .decenasDia(decenasDia), .unidadesMes(unidadesMes),
    .decenasMes(decenasMes), .unidadesYear(unidadesYear), .decenasYear(decenasYear),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready), .busy(busy0), .done(done0)
  );

  typedef struct {
    logic [13:0][3:0] dig;   // [13]=decenasYear ... [0]=centesimas
    int               mode;  // 0: ready held 1, 1: ready 1,0,0,1, 2: zero digits after capture
    logic [167:0]     exp;
  } vec_t;

  vec_t tv[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_digits(input logic [13:0][3:0] d);
    decenasYear     = d[13];
    unidadesYear    = d[12];
    decenasMes      = d[11][0:0];
    unidadesMes     = d[10];
    decenasDia      = d[9][1:0];
    unidadesDia     = d[8];
    decenasHora     = d[7][1:0];
    unidadesHora    = d[6];
    decenasMinuto   = d[5];
    unidadesMinuto  = d[4];
    decenasSegundo  = d[3][2:0];
    unidadesSegundo = d[2];
    decimas         = d[1];
    centesimas      = d[0];
  endtask

  // Called at a negedge; pulses req for one edge and checks 1-cycle latency.
  task automatic start(input bit use0);
    if (use0) req0 = 1'b1; else req = 1'b1;
    @(posedge clk); @(negedge clk);
    req = 1'b0; req0 = 1'b0;
    chk("latency_valid", 32'(use0 ? tx_valid0 : tx_valid), 32'd1);
    chk("latency_busy",  32'(use0 ? busy0 : busy), 32'd1);
  endtask

  // Called at a negedge with a frame in flight; accepts stop_after bytes.
  task automatic collect(input logic [167:0] exp, input int len, input int stop_after,
                         input int mode, input int req_at, input bit use0);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [7:0] held = 8'h00;
    logic v, rdy;
    logic [7:0] d;
    while (got < stop_after && cyc < 300) begin
      v = use0 ? tx_valid0 : tx_valid;
      d = use0 ? tx_data0 : tx_data;
      if (stalled) begin
        chk("stall_valid", 32'(v), 32'd1);
        chk("stall_hold", 32'(d), 32'(held));
      end
      if (mode == 2 && cyc == 0) set_digits('0);
      rdy = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      tx_ready = rdy;
      if (use0) req0 = (got == req_at) && v; else req = (got == req_at) && v;
      if (v && rdy) begin
        chk($sformatf("byte%0d", got), 32'(d), 32'(exp[8*(len-1-got) +: 8]));
        got++;
        stalled = 1'b0;
      end else if (v) begin
        stalled = 1'b1;
        held = d;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    req = 1'b0; req0 = 1'b0;
    chk("byte_count", 32'(got), 32'(stop_after));
    if (stop_after == len) begin
      chk("end_valid", 32'(use0 ? tx_valid0 : tx_valid), 32'd0);
      chk("end_done",  32'(use0 ? done0 : done), 32'd1);
      chk("end_busy",  32'(use0 ? busy0 : busy), 32'd0);
    end
  endtask

  task automatic idle_check;
    @(posedge clk); @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_valid", 32'(tx_valid), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0][3:0] d;
    logic [167:0] e;

    tv[0].dig = {4'd2,4'd5,4'd1,4'd0,4'd3,4'd1,4'd2,4'd3,4'd5,4'd9,4'd5,4'd9,4'd9,4'd9};
    tv[0].mode = 0; tv[0].exp = "25-10-31 23:59:59.99\n";
    tv[1].dig = '0;
    tv[1].mode = 1; tv[1].exp = "00-00-00 00:00:00.00\n";
    tv[2].dig = {4'd9,4'd9,4'd1,4'd2,4'd2,4'd8,4'd1,4'd7,4'd4,4'd5,4'd3,4'd6,4'd0,4'd1};
    tv[2].mode = 1; tv[2].exp = "99-12-28 17:45:36.01\n";
    tv[3].dig = {4'hA,4'hF,4'h1,4'hB,4'h3,4'hC,4'h2,4'hD,4'h5,4'hE,4'h7,4'hF,4'hA,4'h9};
    tv[3].mode = 0; tv[3].exp = "??-1?-3? 2?:5?:7?.?9\n";

    // Reset, with req and tx_ready also high to check reset priority
    rst = 1'b1; req = 1'b1; req0 = 1'b1; tx_ready = 1'b1;
    set_digits(tv[0].dig);
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data",  32'(tx_data), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_valid0", 32'(tx_valid0), 32'd0);
    chk("rst_busy0",  32'(busy0), 32'd0);
    rst = 1'b0; req = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) begin
      set_digits(tv[i].dig);
      start(1'b0);
      collect(tv[i].exp, 21, 21, tv[i].mode, -1, 1'b0);
      idle_check();
    end

    // Capture isolation: digits zeroed the cycle after req
    set_digits(tv[0].dig);
    start(1'b0);
    collect(tv[0].exp, 21, 21, 2, -1, 1'b0);
    idle_check();

    // req while busy is ignored; req on the done cycle starts a new frame
    set_digits(tv[0].dig);
    start(1'b0);
    collect(tv[0].exp, 21, 21, 0, 7, 1'b0);
    start(1'b0);
    chk("restart_first_byte", 32'(tx_data), 32'h32);
    chk("restart_done_low", 32'(done), 32'd0);
    collect(tv[0].exp, 21, 21, 0, -1, 1'b0);
    idle_check();

    // Abort at byte index 12
    set_digits(tv[2].dig);
    start(1'b0);
    collect(tv[2].exp, 21, 12, 0, -1, 1'b0);
    chk("pre_abort_byte12", 32'(tx_data), 32'h34);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", 32'(tx_valid), 32'd0);
    chk("abort_busy",  32'(busy), 32'd0);
    chk("abort_done",  32'(done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_restart", 32'(tx_valid), 32'd0);
    end
    start(1'b0);
    chk("after_abort_byte0", 32'(tx_data), 32'h39);
    collect(tv[2].exp, 21, 21, 0, -1, 1'b0);
    idle_check();

    // No-EOL instance with an out-of-range minute digit
    d = tv[0].dig;
    d[4] = 4'hC;
    set_digits(d);
    e = {8'h00, "25-10-31 23:5?:59.99"};
    start(1'b1);
    collect(e, 20, 20, 0, -1, 1'b1);
    chk("eol0_main_idle", 32'(tx_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("eol0_done_one_cycle", 32'(done0), 32'd0);
    chk("eol0_idle_valid", 32'(tx_valid0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/timestamp_serializer.md
TIMESTAMP_SERIALIZER -- requirements
Module: timestamp_serializer

Interface
REQ-001 The module SHALL have parameter SEND_EOL, default 1; when 1 an ASCII LF (0x0A) SHALL be appended after the last digit.
REQ-002 The module SHALL have parameter DATE_SEP, default 8'h2D ('-'); it is the separator between year, month and day.
REQ-003 The module SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The module SHALL have port req, input, 1 bit: snapshot-and-send request, sampled each rising edge.
REQ-006 The module SHALL have digit inputs for centesimas, decimas, unidadesSegundo, unidadesMinuto, decenasMinuto, unidadesHora, unidadesDia, unidadesMes, unidadesYear and decenasYear, each 4 bits.
REQ-007 The module SHALL have digit inputs decenasSegundo (3 bits), decenasHora (2 bits), decenasDia (2 bits) and decenasMes (1 bit).
REQ-008 The module SHALL have port tx_data, output, 8 bits: ASCII byte offered downstream.
REQ-009 The module SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-010 The module SHALL have port tx_ready, input, 1 bit: downstream accepts a byte when tx_valid and tx_ready are both 1 at a rising edge.
REQ-011 The module SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle pulse after the last byte is accepted.

Function
REQ-013 Frame format SHALL be "YY-MM-DD HH:MM:SS.dc", with 20 bytes in this order:
- decenasYear, unidadesYear, DATE_SEP
- decenasMes, unidadesMes, DATE_SEP
- decenasDia, unidadesDia, 0x20
- decenasHora, unidadesHora, 0x3A
- decenasMinuto, unidadesMinuto, 0x3A
- decenasSegundo, unidadesSegundo, 0x2E
- decimas, centesimas
REQ-014 When SEND_EOL is 1, LF SHALL follow as byte 21.
REQ-015 Each digit SHALL be zero-extended to 4 bits and encoded as 0x30+digit; a digit value >9 SHALL be encoded as 0x3F ('?').
REQ-016 Digit values SHALL be sent verbatim, with no month or day offset applied.
REQ-017 The state machine SHALL have states IDLE and SEND.
- IDLE -> SEND on req=1.
- SEND -> IDLE on acceptance of the last byte.
REQ-018 On the edge where req=1 in IDLE, all 14 digits SHALL be captured into a snapshot register, byte index SHALL be cleared to 0, and the FSM SHALL enter SEND.
REQ-019 tx_valid SHALL rise in the cycle after req is sampled; request-to-first-byte latency is 1 clock.
REQ-020 Digit-input changes after capture SHALL NOT affect the frame in progress.
REQ-021 In SEND, tx_valid SHALL be 1 and tx_data SHALL equal the byte at the current index.
REQ-022 tx_data SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-023 On each accepted byte, the index SHALL increment by 1.
- Next byte is valid the following cycle with no bubble, so one byte per clock is possible when tx_ready is held 1.
REQ-024 On acceptance of the last byte (index 19, or index 20 when SEND_EOL=1):
- FSM SHALL return to IDLE.
- tx_valid SHALL be 0 the next cycle.
- done SHALL be 1 for exactly that next cycle.
REQ-025 busy SHALL equal (state==SEND).
REQ-026 req asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 req asserted in the same cycle done=1 SHALL start a new frame, since the FSM is in IDLE.
REQ-028 tx_ready asserted while tx_valid=0 SHALL have no effect.
REQ-029 The byte index counter SHALL be 5 bits wide and SHALL never exceed the last index.

Reset
REQ-030 When rst=1 at a rising edge, the module SHALL set:
- state = IDLE, index = 0, snapshot = 0
- tx_valid = 0, tx_data = 0x00
- busy = 0, done = 0
REQ-031 rst SHALL take priority over req and tx_ready in the same cycle.
REQ-032 rst mid-frame SHALL abort the frame without asserting done; a frame SHALL restart only on a new req after rst deasserts.

Verification
REQ-033 With tx_ready=1 and digits set to 2,5/1,0/3,1/2,3/5,9/5,9/9,9, pulse req -> 21 consecutive bytes "25-10-31 23:59:59.99\n", then done=1 for 1 cycle and busy=0.
REQ-034 With tx_ready toggling 1,0,0,1 repeatedly -> tx_data stable while stalled; byte count equals 21; no byte duplicated or skipped.
REQ-035 Change every digit to 0 on the cycle after req -> frame still carries the captured values.
REQ-036 Pulse req at byte index 7, then at the done cycle -> first pulse ignored; second pulse starts a new frame with tx_valid=1 one cycle later.
REQ-037 Assert rst at byte index 12 -> next cycle tx_valid=0, busy=0, done never asserted; a new req sends from byte 0.
REQ-038 With unidadesMinuto=4'hC and SEND_EOL=0 -> byte 13 = 0x3F, frame length 20, done after byte 19.
